// File: rtl/regfile_sync.sv
// regfile_sync: 2R/1W register file with byte-enabled writes, write-through bypass, sweep clear and LED byte tap
module regfile_sync #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter bit ZERO_R0 = 1'b1,
  localparam int NB = DATA_W / 8,
  localparam int BW = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clr_Req,
  output logic              Busy,
  input  logic              Write_Reg,
  input  logic [ADDR_W-1:0] W_Addr,
  input  logic [DATA_W-1:0] W_Data,
  input  logic [NB-1:0]     W_BE,
  input  logic [ADDR_W-1:0] R_Addr_A,
  input  logic [ADDR_W-1:0] R_Addr_B,
  output logic [DATA_W-1:0] R_Data_A,
  output logic [DATA_W-1:0] R_Data_B,
  input  logic              Disp_Sel,
  input  logic [BW-1:0]     Disp_Byte,
  output logic [7:0]        LED
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic wr_ok;
  logic [DATA_W-1:0] merged, rd_a, rd_b, disp;
  assign Busy = state == CLEAR;
  assign wr_ok = !Busy && Write_Reg && !(ZERO_R0 && W_Addr == '0);
  always_comb begin
    state_n = (state == IDLE) ? (Clr_Req ? CLEAR : IDLE) : ((ptr == '1) ? IDLE : CLEAR);
  end
  always_comb begin
    merged = mem[W_Addr];
    for (int k = 0; k < NB; k++)
      merged[8*k +: 8] = W_BE[k] ? W_Data[8*k +: 8] : mem[W_Addr][8*k +: 8];
  end
  // the entry being swept this cycle must already read as zero
  assign rd_a = ((ZERO_R0 && R_Addr_A == '0) || (Busy && R_Addr_A == ptr)) ? '0 :
                (wr_ok && R_Addr_A == W_Addr) ? merged : mem[R_Addr_A];
  assign rd_b = ((ZERO_R0 && R_Addr_B == '0) || (Busy && R_Addr_B == ptr)) ? '0 :
                (wr_ok && R_Addr_B == W_Addr) ? merged : mem[R_Addr_B];
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      ptr      <= '0;
      R_Data_A <= '0;
      R_Data_B <= '0;
    end else begin
      state    <= state_n;
      ptr      <= Busy ? ptr + 1'b1 : '0;
      R_Data_A <= rd_a;
      R_Data_B <= rd_b;
    end
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (Busy) begin
      mem[ptr] <= '0;
    end else if (wr_ok) begin
      mem[W_Addr] <= merged;
    end
  end
  assign disp = Disp_Sel ? R_Data_B : R_Data_A;
  assign LED  = 8'(disp >> {Disp_Byte, 3'd0});
endmodule

// File: doc/regfile_sync.md
# regfile_sync

Parametrised two-read/one-write register file with registered reads, byte-enabled writes, write-through bypass, a sequential clear engine and a byte-selectable LED display tap. It generalises the lab-board register file into the datapath register file for the single-cycle/multi-cycle CPU. The LED tap keeps board-level inspection available without extra glue.

## Interface
Parameters:
- DATA_W, 32, word width; must be a multiple of 8.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- ZERO_R0, 1, when 1 entry 0 reads as 0 and ignores writes.

Ports:
- Clk  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-low; clears all entries and all state.
- Clr_Req  in  1  synchronous request to sweep-clear the whole array.
- Busy  out  1  high while the clear sweep runs.
- Write_Reg  in  1  write enable.
- W_Addr  in  ADDR_W  write address.
- W_Data  in  DATA_W  write data.
- W_BE  in  DATA_W/8  per-byte write enable; bit k covers W_Data[8k+7:8k].
- R_Addr_A, R_Addr_B  in  ADDR_W  read addresses.
- R_Data_A, R_Data_B  out  DATA_W  registered read data.
- Disp_Sel  in  1  0 = LED shows port A, 1 = port B.
- Disp_Byte  in  clog2(DATA_W/8)  byte index shown on LED.
- LED  out  8  selected byte of selected read port.

## Operation
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when Clr_Req=1 at a rising edge. Clear pointer loads 0.
  - CLEAR: each cycle writes 0 to entry[ptr], then ptr+1.
  - CLEAR -> IDLE on the cycle that clears entry DEPTH-1.
- Busy=1 exactly while in CLEAR.
- While Busy: Write_Reg is ignored (write dropped, not queued), and Clr_Req is ignored.
- Write (IDLE, Write_Reg=1): for each k with W_BE[k]=1, entry[W_Addr] byte k gets W_Data byte k. Other bytes are kept.
- W_BE=0 is a legal no-op.
- ZERO_R0=1: writes to address 0 are discarded, and reads of address 0 return 0, including via bypass.
- Reads: on every rising edge, R_Data_x <= entry[R_Addr_x], also during CLEAR.
- Bypass: if an accepted write in the same cycle targets R_Addr_x, R_Data_x gets the merged word (new enabled bytes, old other bytes). Both ports bypass independently.
- Bypass during CLEAR: a read of the entry being cleared this cycle returns 0.
- LED = byte Disp_Byte of (Disp_Sel ? R_Data_B : R_Data_A). Combinational from the registered data and the selects.

## Timing
- Reset low (asynchronous):
  - all entries = 0
  - R_Data_A = R_Data_B = 0, LED = 0
  - Busy = 0, FSM = IDLE, ptr = 0
- Release is synchronous to Clk; the first active edge is the first Clk rising edge with Reset high.
- Read latency: 1 cycle (address at edge n, data valid after edge n).
- Write latency: 0 cycles to the bypassed reader; 1 cycle to any later read.
- Clear duration: Clr_Req sampled at edge n gives Busy=1 after edge n. Entries 0..DEPTH-1 are cleared at edges n+1..n+DEPTH, and Busy=0 after edge n+DEPTH.
- Clr_Req held high continuously: a new sweep starts at the first edge in IDLE, so there is one idle cycle between sweeps.
- Reset asserted mid-sweep: an immediate full clear and a return to IDLE with Busy=0. No partial state survives.
- ptr wraps only via the CLEAR->IDLE exit; it never indexes past DEPTH-1.
- Simultaneous Clr_Req and Write_Reg in IDLE: the write is performed at that edge, then the sweep starts next edge and erases it.

## Test plan
- Reset, then write 0x1234_5678 to r3 with W_BE=4'hF. Read r3 next cycle -> R_Data_A=0x1234_5678. Disp_Byte=2 with Disp_Sel=0 -> LED=0x34.
- r5=0x9ABC_DEF0. Write 0x0000_0607 with W_BE=4'b0001. Same-cycle read r5 on both ports -> both give 0x9ABC_DE07. Stored value is 0x9ABC_DE07.
- ZERO_R0=1: write 0xFFFF_FFFF to r0, read r0 on A and B (same cycle and later) -> 0. With ZERO_R0=0, the later read gives 0xFFFF_FFFF.
- Fill all 32 entries with 0x3333_2222 and pulse Clr_Req.
  - Busy is high for exactly 32 cycles.
  - A write to r7 during Busy is dropped.
  - After Busy falls, all reads return 0.
- Deassert Reset for 10 cycles of a sweep (partial clear), then assert Reset -> outputs 0 immediately, Busy=0, all entries 0 after release.
- DATA_W=64, ADDR_W=3: write with W_BE=8'hA5 and sweep Disp_Byte 0..7 -> LED tracks the correct bytes. Clear lasts 8 cycles.
